uart_tx_cfg: RTL
================

# uart_tx_cfg

Configurable UART transmitter, the parametrised successor to the fixed 8N1 transmitter. Frame format (data width, parity, stop bits) is set by parameters. A one-entry holding register behind a valid/ready handshake allows back-to-back frames with no idle gap, and a break input drives a line-break condition. It sits between a byte/word producer (FIFO or command engine) and the serial output pin.

## Interface
- `CLK_FREQ`, 200_000_000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer divide); must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, legal range 5–9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `s_data`  input  DATA_BITS  word to transmit.
- `s_valid`  input  1  `s_data` is valid.
- `s_ready`  output  1  holding register empty; a transfer occurs on an edge where `s_valid && s_ready`.
- `tx_break`  input  1  level request to hold the line low (break).
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  high while a frame, break or mark-after-break is in progress or the holding register is full.

## Operation
- **Reset values:** `tx`=1, `s_ready`=1, `busy`=0, FSM=IDLE, holding register empty, counters zero. Reset mid-frame aborts immediately and drops any held word.
- **Holding register:**
  - `s_ready = !hold_valid`.
  - Accepting a transfer sets `hold_valid` and captures `s_data`.
  - `hold_valid` clears when the FSM loads the word.
- **Frame:** start (0), data LSB first, optional parity, then `STOP_BITS` stop bits (1).
  - Even parity bit = XOR of data bits; odd parity = its inverse.
- **Baud counter:** width `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT-1`, and each line bit lasts exactly `CLKS_PER_BIT` cycles. The bit counter is sized for 9 data bits plus 2 stop bits.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK, MARK.
  - IDLE → BREAK if `tx_break`. Break has priority over a held word.
  - IDLE → START if `hold_valid` (and no break): load shift register, clear `hold_valid`.
  - START → DATA after one bit time.
  - DATA → PARITY (if `PARITY`≠0) or STOP after `DATA_BITS` bit times.
  - PARITY → STOP after one bit time.
  - STOP, after `STOP_BITS` bit times:
    - → START directly if `hold_valid` and `!tx_break`;
    - → BREAK if `tx_break`;
    - otherwise → IDLE.
  - BREAK: `tx`=0 while `tx_break` is high. On deassertion → MARK.
  - MARK: `tx`=1 for one full bit time, then → IDLE.
- `tx_break` asserted mid-frame is ignored until the current frame's stop bits complete.
- Words can still be accepted during BREAK/MARK; they are sent after MARK.
- `tx` is driven from a register, so the line has no glitches.

## Timing
- **Latency:** a transfer accepted on edge N with the FSM in IDLE makes `tx` fall after edge N+1. `s_ready` is low only for the cycle after edge N and returns to 1 after edge N+1.
- **Frame length:** `CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)` cycles from the start-bit edge to the end of the last stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero idle gap. While a frame is active and the holding register is full, `s_ready`=0.
- **Simultaneous accept and load:** on an edge where the FSM loads the held word and a new transfer occurs, the new word is captured. Because `s_ready` was 0 that edge, this cannot happen; the bench checks that no transfer is lost.
- `busy` is registered alongside the state. It deasserts on the edge the FSM enters IDLE with `hold_valid`=0.

## Test plan
All tests use CLK_FREQ=1_000_000 and BAUD_RATE=100_000 (CLKS_PER_BIT=10).
- **8N1, 0xA5:** `tx` bits 0,1,0,1,0,0,1,0,1,1, each exactly 10 cycles (100 total). `busy` deasserts after the frame.
- **7E2, 0x41:** `tx` bits 0,1,0,0,0,0,0,1,0(parity),1,1; 110 cycles.
- **8O1, 0xFF:** parity bit = 1; 0x00 gives parity bit = 1 … check inverted (0x00 → 1, 0xFF → 1 for 8 ones = even count); and 0x01 → 0.
- **Back-to-back 8N1, `s_valid` held high with 0x55 then 0x0F:**
  - the second start bit begins the cycle after the first stop bit;
  - exactly 2 transfers occur;
  - 200 contiguous cycles with no idle-high gap.
- **Break:** `tx_break` high for 50 cycles during a frame. The frame completes, then `tx`=0 until deassert, then `tx`=1 for 10 cycles (MARK). A word queued during break starts only after MARK.
- **Reset mid-frame:** `rst_n` low in the 4th data bit with a word held → `tx`=1, `s_ready`=1, `busy`=0 asynchronously. After release, there is no further output until a new transfer.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits,
// one-entry holding register on a valid/ready input, and line-break generation.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle high, waiting for a held word or a break request
// START  | start bit (0) for one bit time
// DATA   | data bits, LSB first, one bit time each
// PARITY | parity bit (only when PARITY != 0)
// STOP   | STOP_BITS stop bits (1)
// BREAK  | line held low while tx_break is high
// MARK   | line high for one bit time after a break
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 200_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 tx_break,
  output logic                 tx,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       baud_cnt, baud_cnt_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]   shift_q, shift_n;
  logic                   parity_q, parity_n;
  logic                   tx_q, tx_n;
  logic                   busy_q, busy_n;
  logic                   hold_valid, hold_valid_n;
  logic [DATA_BITS-1:0]   hold_data;
  logic                   load;
  logic                   accept;
  logic                   bit_end;

  assign s_ready = !hold_valid;
  assign accept  = s_valid && !hold_valid;
  assign bit_end = (baud_cnt == CNT_LAST);
  assign tx      = tx_q;
  assign busy    = busy_q;

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + 1'b1;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_q;
    parity_n   = parity_q;
    tx_n       = tx_q;
    load       = 1'b0;

    case (state)
      S_IDLE: begin
        baud_cnt_n = '0;
        if (tx_break) begin
          state_n = S_BREAK;
          tx_n    = 1'b0;
        end else if (hold_valid) begin
          state_n = S_START;
          load    = 1'b1;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n    = S_DATA;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          tx_n       = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            if (PARITY != 0) begin
              state_n = S_PARITY;
              tx_n    = parity_q;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
            shift_n   = shift_q >> 1;
            tx_n      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n    = S_STOP;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          tx_n       = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
            // break wins over a held word; the word waits until after MARK
            if (tx_break) begin
              state_n = S_BREAK;
              tx_n    = 1'b0;
            end else if (hold_valid) begin
              state_n = S_START;
              load    = 1'b1;
              tx_n    = 1'b0;
            end else begin
              state_n = S_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      S_BREAK: begin
        baud_cnt_n = '0;
        tx_n       = 1'b0;
        if (!tx_break) begin
          state_n = S_MARK;
          tx_n    = 1'b1;
        end
      end
      S_MARK: begin
        if (bit_end) begin
          state_n    = S_IDLE;
          baud_cnt_n = '0;
        end
      end
      default: begin
        state_n    = S_IDLE;
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
        tx_n       = 1'b1;
      end
    endcase

    if (load) begin
      shift_n  = hold_data;
      parity_n = (PARITY == 2) ? ~(^hold_data) : ^hold_data;
    end

    hold_valid_n = accept ? 1'b1 : (load ? 1'b0 : hold_valid);
    busy_n       = (state_n != S_IDLE) || hold_valid_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift_q    <= shift_n;
      parity_q   <= parity_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
      hold_valid <= hold_valid_n;
      if (accept) hold_data <= s_data;
    end
  end

endmodule
